// File: rtl/dbg_pkg.sv
// Shared types and constants for the commit-trace debugger.
package dbg_pkg;

  typedef enum logic [1:0] {
    RUN,
    DUMP,
    HALTED
  } state_e;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_BRK  = 2'b01;
  localparam logic [1:0] CAUSE_IVD  = 2'b10;

  localparam int unsigned INST_W   = 32;
  // Widest pc a trace entry can carry; narrower cores use the low bits.
  localparam int unsigned PC_W_MAX = 64;

  typedef struct packed {
    logic [PC_W_MAX-1:0] pc;
    logic [INST_W-1:0]   inst;
  } entry_t;

endpackage

// File: rtl/dbg_trace_ram.sv
// Trace storage: DEPTH words of {pc, inst}, NRET write ports, one async read port.
module dbg_trace_ram import dbg_pkg::*; #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NRET  = 1,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned W     = XLEN + INST_W
) (
  input  logic              clk,
  input  logic [NRET-1:0]   we,
  input  logic [NRET*AW-1:0] waddr,
  input  logic [NRET*W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write all enabled channels; addresses within a cycle are distinct.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NRET; i++) begin
      if (we[i]) begin
        mem[waddr[i*AW +: AW]] <= wdata[i*W +: W];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dbg_trace_buf.sv
// Commit-trace debugger: records retiring pc/inst pairs into a ring, freezes on
// ebreak/invalid, streams the history out oldest first, then holds the core halted.
module dbg_trace_buf import dbg_pkg::*; #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NRET  = 1,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NRET-1:0]    commit_valid,
  input  logic [NRET*XLEN-1:0] commit_pc,
  input  logic [NRET*32-1:0] commit_inst,
  input  logic [NRET-1:0]    commit_brk,
  input  logic [NRET-1:0]    commit_ivd,
  output logic               dump_valid,
  input  logic               dump_ready,
  output logic [XLEN-1:0]    dump_pc,
  output logic [31:0]        dump_inst,
  output logic               dump_last,
  output logic               halted,
  output logic [1:0]         halt_cause,
  output logic [XLEN-1:0]    halt_pc,
  output logic [CNT_W-1:0]   retired_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned W  = XLEN + INST_W;

  state_e           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic             halted_q, halted_d;
  logic [1:0]       cause_q, cause_d;
  logic [XLEN-1:0]  hpc_q, hpc_d;

  logic [NRET-1:0]    we;
  logic [NRET*AW-1:0] waddr;
  logic [NRET*W-1:0]  wdata;
  logic [CW-1:0]      n_wr;
  logic               trig;
  logic [1:0]         trig_cause;
  logic [XLEN-1:0]    trig_pc;
  logic [W-1:0]       rdata;
  logic [CW:0]        sum;
  logic [CNT_W:0]     rsum;

  // Pick the channels to record: valid ones up to and including the first trigger.
  always_comb begin
    we         = '0;
    waddr      = '0;
    wdata      = '0;
    n_wr       = '0;
    trig       = 1'b0;
    trig_cause = CAUSE_NONE;
    trig_pc    = '0;
    for (int i = 0; i < NRET; i++) begin
      waddr[i*AW +: AW] = wr_ptr_q + n_wr[AW-1:0];
      wdata[i*W +: W]   = {commit_pc[i*XLEN +: XLEN], commit_inst[i*32 +: 32]};
      if (state_q == RUN && commit_valid[i] && !trig) begin
        we[i] = 1'b1;
        n_wr  = n_wr + CW'(1);
        if (commit_brk[i] || commit_ivd[i]) begin
          trig       = 1'b1;
          trig_cause = commit_ivd[i] ? CAUSE_IVD : CAUSE_BRK;
          trig_pc    = commit_pc[i*XLEN +: XLEN];
        end
      end
    end
  end

  // Next-state: ring bookkeeping in RUN, read-out stepping in DUMP.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ret_d    = ret_q;
    halted_d = halted_q;
    cause_d  = cause_q;
    hpc_d    = hpc_q;
    sum      = '0;
    rsum     = '0;
    case (state_q)
      RUN: begin
        wr_ptr_d = wr_ptr_q + n_wr[AW-1:0];
        sum      = {1'b0, count_q} + {1'b0, n_wr};
        count_d  = (sum > (CW+1)'(DEPTH)) ? CW'(DEPTH) : sum[CW-1:0];
        rsum     = {1'b0, ret_q} + (CNT_W+1)'(n_wr);
        ret_d    = rsum[CNT_W] ? '1 : rsum[CNT_W-1:0];
        if (trig) begin
          state_d  = DUMP;
          halted_d = 1'b1;
          cause_d  = trig_cause;
          hpc_d    = trig_pc;
          // A full ring gives count mod DEPTH == 0, so oldest == next write slot.
          rd_ptr_d = wr_ptr_d - count_d[AW-1:0];
        end
      end
      DUMP: begin
        if (dump_ready) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          count_d  = count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_d = HALTED;
          end
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = HALTED;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ret_q    <= '0;
      halted_q <= 1'b0;
      cause_q  <= CAUSE_NONE;
      hpc_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ret_q    <= ret_d;
      halted_q <= halted_d;
      cause_q  <= cause_d;
      hpc_q    <= hpc_d;
    end
  end

  dbg_trace_ram #(
    .XLEN  (XLEN),
    .NRET  (NRET),
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  assign dump_valid  = (state_q == DUMP);
  assign dump_last   = dump_valid && (count_q == CW'(1));
  assign dump_pc     = rdata[W-1 -: XLEN];
  assign dump_inst   = rdata[INST_W-1:0];
  assign halted      = halted_q;
  assign halt_cause  = cause_q;
  assign halt_pc     = hpc_q;
  assign retired_cnt = ret_q;

endmodule

// File: doc/dbg_trace_buf.md
Name: dbg_trace_buf

Overview:
Parametrised commit-trace debugger. It watches up to NRET retiring instructions per cycle and records each pc/inst pair into a DEPTH-entry ring buffer. On ebreak or an invalid instruction it freezes the buffer and streams the last entries out, oldest first, over a valid/ready dump port. It then holds the core in a halted state. It sits beside the commit stage in the core top level and replaces the single-slot per-cycle debug hook with a history the testbench or host harness can drain.

Parameters:
XLEN, 32, pc width in bits
NRET, 1, commit channels per cycle (1..4)
DEPTH, 16, ring entries; power of two, DEPTH >= 2*NRET
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
commit_valid  in  NRET  channel i retires this cycle; must be contiguous from channel 0
commit_pc  in  NRET*XLEN  pc of channel i, slice [i*XLEN +: XLEN]
commit_inst  in  NRET*32  instruction word of channel i
commit_brk  in  NRET  channel i is ebreak
commit_ivd  in  NRET  channel i is an invalid instruction
dump_valid  out  1  dump entry available
dump_ready  in  1  consumer accepts the entry
dump_pc  out  XLEN  pc of the current dump entry
dump_inst  out  32  inst of the current dump entry
dump_last  out  1  current entry is the final one
halted  out  1  freeze active; the core must stop committing
halt_cause  out  2  00 none, 01 ebreak, 10 invalid
halt_pc  out  XLEN  pc of the faulting instruction
retired_cnt  out  CNT_W  number of recorded entries since reset

Behaviour:
- Reset (async, immediate):
  - state=RUN; wr_ptr=0; count=0; rd_ptr=0.
  - dump_valid=0, dump_last=0, halted=0, halt_cause=00, halt_pc=0, retired_cnt=0.
  - dump_pc and dump_inst are don't-care while dump_valid=0.
- States:
  - RUN: record commits.
  - DUMP: stream the buffer out.
  - HALTED: idle until reset.
- RUN, recording:
  - Each valid channel i (ascending order) is written at (wr_ptr+i) mod DEPTH.
  - wr_ptr advances by the number of written entries, wrapping mod DEPTH.
  - count = min(count + written, DEPTH); the oldest entries are overwritten silently.
  - retired_cnt increments by the number written and saturates at all-ones.
- RUN, trigger:
  - k = lowest channel with commit_valid & (commit_brk | commit_ivd).
  - Channels 0..k are recorded, including the faulting entry; channels above k are discarded and not counted.
  - halt_cause: 10 if commit_ivd[k], else 01; ivd wins when both are set on the same channel.
  - halt_pc = commit_pc[k].
  - halted=1 and state=DUMP from the next cycle.
  - rd_ptr = (new wr_ptr - new count) mod DEPTH.
  - Triggers on higher channels in the same cycle are ignored.
- DUMP:
  - The buffer always holds at least 1 entry.
  - dump_valid=1; dump_pc/dump_inst come from ring[rd_ptr] as a registered or direct read, with no bubble between entries.
  - Output is oldest first.
  - dump_last=1 when exactly one entry remains.
  - A transfer happens on dump_valid & dump_ready: rd_ptr advances (wrap), remaining decrements.
  - The transfer that carries dump_last moves the state to HALTED.
  - While dump_ready=0, all dump_* outputs hold stable.
- HALTED:
  - dump_valid=0; halted=1.
  - commit_* inputs are ignored in DUMP and HALTED.
  - Only reset exits this state.
- A reset asserted mid-dump aborts the stream at once; there is no partial completion.

Decomposition:
- Package dbg_pkg:
  - enum state_e {RUN, DUMP, HALTED}
  - halt_cause constants CAUSE_NONE=2'b00, CAUSE_BRK=2'b01, CAUSE_IVD=2'b10
  - entry struct {pc, inst}
- Sub-module dbg_trace_ram: DEPTH x (XLEN+32) storage, NRET write ports, 1 async read port, no reset on contents.
- The FSM, pointers and counters stay in the top module.

Test Plan:
- NRET=1, DEPTH=4: commit pc 0x80000000, 0x80000004, 0x80000008, then brk at 0x8000000C, dump_ready=1 -> 4 dumps in that order, dump_last on the 4th, halt_cause=01, halt_pc=0x8000000C, retired_cnt=4.
- NRET=1, DEPTH=4: 9 normal commits at pc 0x80000000+4n (n=0..8), then ivd at 0x80000024 -> dump 0x80000018, 0x8000001C, 0x80000020, 0x80000024; halt_cause=10, retired_cnt=10.
- NRET=2: cycle with valid=11, brk on ch0 at 0x100, ch1 at 0x104 -> ch1 dropped, last dump entry pc=0x100, retired_cnt excludes 0x104.
- Backpressure: in DUMP hold dump_ready=0 for 3 cycles -> dump_valid=1 with pc/inst unchanged; the entry advances only on the ready cycle.
- Same channel has brk=1 and ivd=1 -> halt_cause=10; a single-entry buffer gives dump_last=1 on the first beat.
- Assert reset after the 2nd dump beat -> dump_valid, halted, retired_cnt and halt_cause read 0 in the same cycle; new commits record normally afterwards.
